// File: rtl/select_and_encode_pkg.sv
// rtl/select_and_encode_pkg.sv - shared CPU constants for instruction field decoding
package select_and_encode_pkg;

    // Instruction field bit positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;
    localparam int C_MSB   = 18;
    localparam int C_LSB   = 0;

    // Register file geometry
    localparam int REG_COUNT = 16;
    localparam int REG_SEL_W = 4;

    typedef logic [REG_SEL_W-1:0] reg_sel_t;
    typedef logic [REG_COUNT-1:0] reg_vec_t;

    // Sign-extend the 19-bit constant field to a full 32-bit word
    function automatic logic [31:0] sign_extend_c(input logic [31:0] ir);
        return {{(31 - C_MSB){ir[C_MSB]}}, ir[C_MSB:C_LSB]};
    endfunction

endpackage

// File: rtl/select_and_encode_decoder_4to16.sv
// rtl/select_and_encode_decoder_4to16.sv - combinational 4-to-16 one-hot decoder
module decoder_4to16
    import select_and_encode_pkg::*;
(
    input  logic [REG_SEL_W-1:0] i_sel,
    output logic [REG_COUNT-1:0] o_dec
);

    // Exactly one bit is always set, so register 0 is selected when i_sel is 0
    always_comb begin
        o_dec        = '0;
        o_dec[i_sel] = 1'b1;
    end

endmodule

// File: rtl/select_and_encode.sv
// rtl/select_and_encode.sv - register select, one-hot encode and constant sign-extend
module select_and_encode
    import select_and_encode_pkg::*;
#(
    parameter int BITS = 32
)(
    input  logic              clk,
    input  logic              clr_n,
    input  logic [BITS-1:0]   IR,
    input  logic              Gra,
    input  logic              Grb,
    input  logic              Grc,
    input  logic              Rin,
    input  logic              Rout,
    input  logic              BAout,
    output logic [BITS/2-1:0] reg_in_ctrl,
    output logic [BITS/2-1:0] reg_out_ctrl,
    output logic [BITS-1:0]   c_sign_extended,
    output logic [BITS/2-1:0] decoder_out,
    output logic [BITS/4-1:0] decoder_in
);

    reg_sel_t w_ra;
    reg_sel_t w_rb;
    reg_sel_t w_rc;
    reg_sel_t w_sel;
    reg_vec_t w_dec;
    reg_vec_t w_in_next;
    reg_vec_t w_out_next;
    logic     w_drive;
    logic [BITS-1:0] w_c_next;

    // Opcode bits are deliberately ignored by every output
    logic w_unused_opcode;
    assign w_unused_opcode = ^IR[OPC_MSB:OPC_LSB];

    logic [BITS/2-1:0] r_reg_in_ctrl;
    logic [BITS/2-1:0] r_reg_out_ctrl;
    logic [BITS-1:0]   r_c_sign_extended;
    logic [BITS/2-1:0] r_decoder_out;
    logic [BITS/4-1:0] r_decoder_in;

    assign w_ra = IR[RA_MSB:RA_LSB];
    assign w_rb = IR[RB_MSB:RB_LSB];
    assign w_rc = IR[RC_MSB:RC_LSB];

    // Gated fields are ORed without priority; no Gr asserted gives register 0
    always_comb begin
        w_sel = ({REG_SEL_W{Gra}} & w_ra)
              | ({REG_SEL_W{Grb}} & w_rb)
              | ({REG_SEL_W{Grc}} & w_rc);
    end

    decoder_4to16 u_decoder (
        .i_sel (w_sel),
        .o_dec (w_dec)
    );

    // BAout gates the drive vector exactly like Rout
    always_comb begin
        w_drive    = Rout | BAout;
        w_in_next  = Rin     ? w_dec : '0;
        w_out_next = w_drive ? w_dec : '0;
        w_c_next   = sign_extend_c(IR);
    end

    // All outputs registered every cycle; asynchronous clear forces them to zero
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_reg_in_ctrl     <= '0;
            r_reg_out_ctrl    <= '0;
            r_c_sign_extended <= '0;
            r_decoder_out     <= '0;
            r_decoder_in      <= '0;
        end else begin
            r_reg_in_ctrl     <= w_in_next;
            r_reg_out_ctrl    <= w_out_next;
            r_c_sign_extended <= w_c_next;
            r_decoder_out     <= w_dec;
            r_decoder_in      <= {{(BITS/4 - REG_SEL_W){1'b0}}, w_sel};
        end
    end

    assign reg_in_ctrl     = r_reg_in_ctrl;
    assign reg_out_ctrl    = r_reg_out_ctrl;
    assign c_sign_extended = r_c_sign_extended;
    assign decoder_out     = r_decoder_out;
    assign decoder_in      = r_decoder_in;

endmodule

// File: tb/tb_select_and_encode.sv
// tb/tb_select_and_encode.sv - directed self-checking bench for select_and_encode
module tb_select_and_encode;

    logic        clk;
    logic        clr_n;
    logic [31:0] IR;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic [15:0] reg_in_ctrl;
    logic [15:0] reg_out_ctrl;
    logic [31:0] c_sign_extended;
    logic [15:0] decoder_out;
    logic [7:0]  decoder_in;

    int n_checks = 0;
    int n_fail   = 0;

    select_and_encode #(.BITS(32)) dut (
        .clk             (clk),
        .clr_n           (clr_n),
        .IR              (IR),
        .Gra             (Gra),
        .Grb             (Grb),
        .Grc             (Grc),
        .Rin             (Rin),
        .Rout            (Rout),
        .BAout           (BAout),
        .reg_in_ctrl     (reg_in_ctrl),
        .reg_out_ctrl    (reg_out_ctrl),
        .c_sign_extended (c_sign_extended),
        .decoder_out     (decoder_out),
        .decoder_in      (decoder_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] e_din, input logic [15:0] e_dout,
                             input logic [15:0] e_in, input logic [15:0] e_out, input logic [31:0] e_c);
        check({tag, ".decoder_in"},      {24'd0, decoder_in},   {24'd0, e_din});
        check({tag, ".decoder_out"},     {16'd0, decoder_out},  {16'd0, e_dout});
        check({tag, ".reg_in_ctrl"},     {16'd0, reg_in_ctrl},  {16'd0, e_in});
        check({tag, ".reg_out_ctrl"},    {16'd0, reg_out_ctrl}, {16'd0, e_out});
        check({tag, ".c_sign_extended"}, c_sign_extended,       e_c);
    endtask

    task automatic drive(input logic [31:0] ir, input logic a, input logic b, input logic c,
                         input logic ri, input logic ro, input logic ba);
        IR = ir; Gra = a; Grb = b; Grc = c; Rin = ri; Rout = ro; BAout = ba;
    endtask

    // advance to the next rising edge, then sample 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr_n = 1'b1;
        drive(32'h1B06_8000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        // asynchronous reset with active inputs, no clock edge in between
        #2 clr_n = 1'b0;
        #1;
        check_all("reset_async", 8'h00, 16'h0000, 16'h0000, 16'h0000, 32'h0000_0000);

        // outputs stay zero across clock edges while held in reset
        step();
        step();
        check_all("reset_held", 8'h00, 16'h0000, 16'h0000, 16'h0000, 32'h0000_0000);

        // release away from the edge, then Ra select with Rin
        @(negedge clk);
        clr_n = 1'b1;
        drive(32'h1B06_8000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check_all("ra_rin", 8'h06, 16'h0040, 16'h0040, 16'h0000, 32'hFFFE_8000);

        // Rc select with Rout; also confirm one-cycle latency before the edge
        @(negedge clk);
        drive(32'h1B06_8000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        check("latency_hold.decoder_in", {24'd0, decoder_in}, 32'h0000_0006);
        step();
        check_all("rc_rout", 8'h0D, 16'h2000, 16'h0000, 16'h2000, 32'hFFFE_8000);

        // Rb select (field is 0) with BAout gating the drive vector
        @(negedge clk);
        drive(32'h1B06_8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check_all("rb_baout", 8'h00, 16'h0001, 16'h0000, 16'h0001, 32'hFFFE_8000);

        // all selects ORed, both strobes together
        @(negedge clk);
        drive(32'h1B06_8000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        check_all("all_gr", 8'h0F, 16'h8000, 16'h8000, 16'h8000, 32'hFFFE_8000);

        // nothing selected, positive constant
        @(negedge clk);
        drive(32'h0000_0123, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_all("no_gr", 8'h00, 16'h0001, 16'h0000, 16'h0000, 32'h0000_0123);

        // opcode bits flipped: same fields as ra_rin, outputs must be identical
        @(negedge clk);
        drive(32'hFB06_8000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check_all("opcode_ignored", 8'h06, 16'h0040, 16'h0040, 16'h0000, 32'hFFFE_8000);

        // Ra=5 and Rb=10 ORed gives 15; Rin and BAout together; C = 0x3FFFF positive
        @(negedge clk);
        drive({5'b00000, 4'h5, 4'hA, 19'h3_FFFF}, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        check_all("or_no_priority", 8'h0F, 16'h8000, 16'h8000, 16'h8000, 32'h0003_FFFF);

        // reset mid-operation, between edges
        @(negedge clk);
        clr_n = 1'b0;
        #1;
        check_all("reset_midop", 8'h00, 16'h0000, 16'h0000, 16'h0000, 32'h0000_0000);

        // release and confirm outputs follow at the next edge
        @(negedge clk);
        clr_n = 1'b1;
        drive(32'h1B06_8000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        check_all("after_release", 8'h0D, 16'h2000, 16'h2000, 16'h0000, 32'hFFFE_8000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/select_and_encode.md
SELECT_AND_ENCODE -- requirements
Module: select_and_encode

Interface
REQ-001 Parameter BITS, default 32, instruction/data word width; only BITS=32 is required to work.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 clr_n  input  1  asynchronous, active-low reset.
REQ-004 IR  input  BITS  instruction word: opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15], C IR[18:0].
REQ-005 Gra  input  1  select Ra field.
REQ-006 Grb  input  1  select Rb field.
REQ-007 Grc  input  1  select Rc field.
REQ-008 Rin  input  1  enable register-input strobe.
REQ-009 Rout  input  1  enable register-output strobe.
REQ-010 BAout  input  1  base-address output strobe; acts as Rout for gating.
REQ-011 reg_in_ctrl  output  BITS/2  one-hot register write-enable vector (R0..R15).
REQ-012 reg_out_ctrl  output  BITS/2  one-hot register drive-enable vector (R0..R15).
REQ-013 c_sign_extended  output  BITS  IR[18:0] sign-extended to BITS.
REQ-014 decoder_out  output  BITS/2  one-hot decode of the selected register number.
REQ-015 decoder_in  output  BITS/4  selected register number; bits [3:0] used, bits [7:4] always 0.

Function
REQ-016 sel = ({4{Gra}} & Ra) | ({4{Grb}} & Rb) | ({4{Grc}} & Rc) (bitwise OR of gated fields, no priority).
REQ-017 With no Gr asserted sel SHALL be 0.
REQ-018 dec = 16-bit one-hot with bit sel set; exactly one bit always set (sel=0 -> 0x0001).
REQ-019 in_next = dec when Rin=1, else 0x0000.
REQ-020 out_next = dec when (Rout | BAout)=1, else 0x0000.
REQ-021 c_next = {13{IR[18]}, IR[18:0]}.
REQ-022 All five outputs SHALL be registered: sampled from current inputs on each rising clk edge; latency exactly 1 cycle, no enable, new value every cycle.
REQ-023 decoder_in register = {4'b0000, sel}; decoder_out register = dec.
REQ-024 Rin and Rout/BAout asserted together SHALL drive both vectors with the same one-hot value.
REQ-025 Opcode bits IR[31:27] SHALL have no effect on any output.

Reset
REQ-026 clr_n=0 SHALL immediately (asynchronously) force every output register to 0, including decoder_out=0x0000.
REQ-027 Outputs SHALL remain 0 while clr_n=0; first non-zero values appear at the first rising clk after clr_n deasserts.
REQ-028 Reset asserted mid-operation SHALL clear outputs without waiting for a clock edge.

Structure
REQ-029 Field bit positions (opcode 31:27, Ra 26:23, Rb 22:19, Rc 18:15, C 18:0) and register count 16 SHALL be constants in the shared CPU package.
REQ-030 A single sub-module decoder_4to16 (4-bit in, 16-bit one-hot out, combinational) SHALL implement dec; the rest is inline logic plus one output register block.

Verification
REQ-031 clr_n=0, any inputs -> all outputs 0 without a clock edge; release, next edge -> outputs follow inputs.
REQ-032 IR=0x1B068000, Gra=1 only, Rin=1 -> after 1 edge: decoder_in=0x06, decoder_out=0x0040, reg_in_ctrl=0x0040, reg_out_ctrl=0x0000, c_sign_extended=0xFFFE8000.
REQ-033 Same IR, Grc=1 only, Rout=1 -> decoder_in=0x0D, decoder_out=0x2000, reg_out_ctrl=0x2000, reg_in_ctrl=0x0000.
REQ-034 Same IR, Grb=1 only, BAout=1 -> decoder_in=0x00, decoder_out=0x0001, reg_out_ctrl=0x0001.
REQ-035 Same IR, Gra=Grb=Grc=1, Rin=Rout=1 -> decoder_in=0x0F, decoder_out=reg_in_ctrl=reg_out_ctrl=0x8000.
REQ-036 IR=0x00000123, no Gr, Rin=Rout=BAout=0 -> decoder_in=0x00, decoder_out=0x0001, both ctrl vectors 0x0000, c_sign_extended=0x00000123.
